fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_2000, meaning the first fetch address after reset.
REQ-002 The block SHALL have parameter NOP_INST, default 32'h0000_0013 (addi x0,x0,0), meaning the bubble instruction.
REQ-003 clk  in  1  the only clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 PC_Sel  in  2  redirect select; 2'd1 = ALU target, every other code = sequential.
REQ-006 alu_target  in  32  redirect address from stage X.
REQ-007 Inst_Kill  in  1  squashes the instruction presented this cycle.
REQ-008 stall  in  1  decode cannot accept an instruction this cycle.
REQ-009 icache_addr  out  32  fetch request address.
REQ-010 icache_re  out  1  fetch request strobe; the request is accepted in the cycle it is high.
REQ-011 icache_dout  in  32  response data.
REQ-012 icache_resp_valid  in  1  icache_dout holds the response to the oldest accepted request.
REQ-013 inst  out  32  instruction handed to decode/control.
REQ-014 pc_I  out  32  address of the instruction on inst.
REQ-015 inst_valid  out  1  inst is a real, unsquashed instruction.

Function
REQ-016 The block SHALL implement states ISSUE, RUN, WAIT and HOLD, with at most one outstanding icache request.
REQ-017 The issue address SHALL be chosen by priority: PC_Sel==1 gives alu_target; otherwise redir_pend gives redir_tgt; otherwise fetch_pc. Bits [1:0] SHALL be forced to 0.
REQ-018 icache_addr SHALL equal the issue address in every cycle.
REQ-019 icache_re SHALL be high in ISSUE, high in RUN/WAIT when icache_resp_valid=1 and stall=0, and low otherwise.
REQ-020 On every cycle with icache_re high: pc_I <= issue address; fetch_pc <= issue address + 4 (mod 2^32); redir_pend <= 0; squash <= 0.
REQ-021 ISSUE SHALL go to RUN.
REQ-022 RUN/WAIT with resp_valid=0 SHALL go to WAIT.
REQ-023 RUN/WAIT with resp_valid=1 and stall=0 SHALL go to RUN, delivering the response.
REQ-024 RUN/WAIT with resp_valid=1 and stall=1 SHALL go to HOLD and capture icache_dout into hold_inst.
REQ-025 HOLD with stall=1 SHALL stay in HOLD with icache_re=0.
REQ-026 HOLD with stall=0 SHALL deliver hold_inst and go to ISSUE.
REQ-027 Delivery: inst = response (RUN/WAIT) or hold_inst (HOLD), and inst_valid=1, unless squashed.
REQ-028 An instruction is squashed if Inst_Kill=1, or the squash flag is set, or redir_pend=1.
REQ-029 When not delivering (ISSUE, no response, or squashed), inst SHALL be NOP_INST and inst_valid SHALL be 0.
REQ-030 PC_Sel==1 in a cycle with icache_re low SHALL set redir_pend=1, redir_tgt=alu_target and squash=1; the pending or held instruction is then discarded.
REQ-031 A later PC_Sel==1 while redir_pend=1 SHALL overwrite redir_tgt.
REQ-032 A squashed response SHALL still complete the handshake (state transitions as in REQ-022..026) but SHALL never assert inst_valid.
REQ-033 pc_I SHALL remain stable while in WAIT or HOLD.
REQ-034 hold_inst SHALL not change while in HOLD.

Reset
REQ-035 While reset is high, asynchronously: state=ISSUE, fetch_pc=RESET_PC, pc_I=RESET_PC, redir_pend=0, redir_tgt=0, squash=0, hold_inst=NOP_INST.
REQ-036 Reset values as seen at the outputs: inst=NOP_INST, inst_valid=0, icache_re=1, icache_addr=RESET_PC.
REQ-037 Reset asserted mid-WAIT or mid-HOLD SHALL abandon the outstanding request. After release, the first response seen SHALL belong to the RESET_PC request.

Verification
REQ-038 Boot: release reset; resp_valid=1 with 32'h00500093 one cycle later -> inst=32'h00500093, pc_I=0x2000, inst_valid=1, icache_addr=0x2004, icache_re=1.
REQ-039 Redirect on advance: PC_Sel=1, alu_target=0x2101, Inst_Kill=1 with a response valid -> inst=NOP_INST, inst_valid=0, icache_addr=0x2100 in the same cycle, and pc_I=0x2100 next cycle.
REQ-040 Miss: resp_valid=0 for 3 cycles -> state WAIT, icache_re=0, inst_valid=0, pc_I stable; resp_valid=1 on cycle 4 -> instruction delivered once.
REQ-041 Stall: resp_valid=1 with stall=1 for 2 cycles -> HOLD, icache_re=0, inst_valid=0; stall=0 -> hold_inst delivered exactly once, then ISSUE at pc_I+4.
REQ-042 Redirect in WAIT: PC_Sel=1, alu_target=0x3000 while waiting -> the arriving response is squashed (inst_valid=0), then icache_addr=0x3000 is issued.
REQ-043 Wrap: fetch_pc=0xFFFFFFFC issued -> next sequential icache_addr=0x00000000.
REQ-044 Async reset asserted mid-HOLD -> outputs match REQ-036 without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding icache request, redirect/squash
// tracking, and a one-entry hold buffer for instructions that decode cannot take yet.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_2000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  PC_Sel,
    input  logic [31:0] alu_target,
    input  logic        Inst_Kill,
    input  logic        stall,
    output logic [31:0] icache_addr,
    output logic        icache_re,
    input  logic [31:0] icache_dout,
    input  logic        icache_resp_valid,
    output logic [31:0] inst,
    output logic [31:0] pc_I,
    output logic        inst_valid,
    output logic [1:0]  fsm_state
);

    // Handshake: a request is accepted in any cycle icache_re is high; the
    // response arrives in a later cycle marked by icache_resp_valid and always
    // answers the oldest (only) accepted request.
    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        RUN   = 2'd1,
        WAIT  = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] fetch_pc;
    logic [31:0] redir_tgt;
    logic        redir_pend;
    logic        squash;
    logic [31:0] hold_inst;

    logic [31:0] issue_addr;
    logic        resp_here;
    logic        deliver;
    logic        killed;

    assign fsm_state = state;

    always_comb begin
        issue_addr = fetch_pc;
        if (PC_Sel == 2'd1)
            issue_addr = alu_target;
        else if (redir_pend)
            issue_addr = redir_tgt;
        issue_addr[1:0] = 2'b00;
    end

    assign icache_addr = issue_addr;
    assign resp_here   = ((state == RUN) || (state == WAIT)) && icache_resp_valid;
    assign icache_re   = (state == ISSUE) || (resp_here && !stall);
    assign killed      = Inst_Kill || squash || redir_pend;

    always_comb begin
        state_nxt  = state;
        deliver    = 1'b0;
        inst       = NOP_INST;
        inst_valid = 1'b0;
        case (state)
            ISSUE: state_nxt = RUN;
            RUN, WAIT: begin
                if (!icache_resp_valid)
                    state_nxt = WAIT;
                else if (stall)
                    state_nxt = HOLD;
                else begin
                    state_nxt = RUN;
                    deliver   = 1'b1;
                end
            end
            HOLD: begin
                if (!stall) begin
                    state_nxt = ISSUE;
                    deliver   = 1'b1;
                end
            end
            default: state_nxt = ISSUE;
        endcase
        // Squashed deliveries still retire the handshake, they just show a bubble.
        if (deliver && !killed) begin
            inst       = (state == HOLD) ? hold_inst : icache_dout;
            inst_valid = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ISSUE;
            fetch_pc   <= RESET_PC;
            pc_I       <= RESET_PC;
            redir_pend <= 1'b0;
            redir_tgt  <= 32'h0;
            squash     <= 1'b0;
            hold_inst  <= NOP_INST;
        end else begin
            state <= state_nxt;
            if (icache_re) begin
                pc_I       <= issue_addr;
                fetch_pc   <= issue_addr + 32'd4;
                redir_pend <= 1'b0;
                squash     <= 1'b0;
            end else if (PC_Sel == 2'd1) begin
                redir_pend <= 1'b1;
                redir_tgt  <= alu_target;
                squash     <= 1'b1;
            end
            if (resp_here && stall)
                hold_inst <= icache_dout;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized-latency bench for fetch_stage; delivered
// instructions are checked in order against an expected queue.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic [1:0]  PC_Sel;
    logic [31:0] alu_target;
    logic        Inst_Kill;
    logic        stall;
    logic [31:0] icache_addr;
    logic        icache_re;
    logic [31:0] icache_dout;
    logic        icache_resp_valid;
    logic [31:0] inst;
    logic [31:0] pc_I;
    logic        inst_valid;
    logic [1:0]  fsm_state;

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [63:0] exp_q[$];

    fetch_stage dut (
        .clk(clk), .reset(reset), .PC_Sel(PC_Sel), .alu_target(alu_target),
        .Inst_Kill(Inst_Kill), .stall(stall), .icache_addr(icache_addr),
        .icache_re(icache_re), .icache_dout(icache_dout),
        .icache_resp_valid(icache_resp_valid), .inst(inst), .pc_I(pc_I),
        .inst_valid(inst_valid), .fsm_state(fsm_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDC;
    endfunction

    // driver: inputs change 1ns after the rising edge, checks follow 1ns later
    task automatic drive(input logic rv, input logic [31:0] d, input logic st,
                         input logic kill, input logic [1:0] psel, input logic [31:0] tgt);
        @(posedge clk);
        #1;
        icache_resp_valid = rv;
        icache_dout       = d;
        stall             = st;
        Inst_Kill         = kill;
        PC_Sel            = psel;
        alu_target        = tgt;
        #1;
    endtask

    // scoreboard: every valid delivery must match the oldest expectation
    always @(negedge clk) begin
        if (!reset && inst_valid) begin
            if (exp_q.size() == 0) begin
                chk("spurious_valid", {31'b0, inst_valid}, 32'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("inst", inst, e[31:0]);
                chk("pc_I", pc_I, e[63:32]);
            end
        end
    end

    initial begin
        logic [31:0] pc;
        int k, s;
        reset = 1'b1;
        PC_Sel = 2'd0; alu_target = 32'h0; Inst_Kill = 1'b0; stall = 1'b0;
        icache_dout = 32'h0; icache_resp_valid = 1'b0;
        #12;
        chk("rst_inst", inst, NOP);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_re", {31'b0, icache_re}, 32'd1);
        chk("rst_addr", icache_addr, 32'h2000);
        chk("rst_pc_I", pc_I, 32'h2000);
        chk("rst_state", {30'b0, fsm_state}, 32'd0);

        // boot
        @(posedge clk); #1 reset = 1'b0;
        drive(1, 32'h0050_0093, 0, 0, 2'd0, 0);
        exp_q.push_back({32'h2000, 32'h0050_0093});
        chk("boot_addr", icache_addr, 32'h2004);
        chk("boot_re", {31'b0, icache_re}, 32'd1);

        // redirect while advancing, with kill
        drive(1, word_of(32'h2004), 0, 1, 2'd1, 32'h2101);
        chk("redir_addr", icache_addr, 32'h2100);
        chk("redir_inst", inst, NOP);
        chk("redir_valid", {31'b0, inst_valid}, 32'd0);

        // miss for three cycles
        for (int i = 0; i < 3; i++) begin
            drive(0, 32'hDEAD_BEEF, 0, 0, 2'd0, 0);
            chk("miss_re", {31'b0, icache_re}, 32'd0);
            chk("miss_valid", {31'b0, inst_valid}, 32'd0);
            chk("miss_pc_I", pc_I, 32'h2100);
            if (i > 0) chk("miss_state", {30'b0, fsm_state}, 32'd2);
        end
        drive(1, word_of(32'h2100), 0, 0, 2'd0, 0);
        exp_q.push_back({32'h2100, word_of(32'h2100)});
        chk("miss_done_addr", icache_addr, 32'h2104);

        // stall for two cycles, then release
        drive(1, word_of(32'h2104), 1, 0, 2'd0, 0);
        chk("stall_re0", {31'b0, icache_re}, 32'd0);
        chk("stall_valid0", {31'b0, inst_valid}, 32'd0);
        drive(0, 32'hBAD0_BAD0, 1, 0, 2'd0, 0);
        chk("hold_state", {30'b0, fsm_state}, 32'd3);
        chk("hold_re", {31'b0, icache_re}, 32'd0);
        chk("hold_pc_I", pc_I, 32'h2104);
        drive(0, 32'hBAD1_BAD1, 0, 0, 2'd0, 0);
        exp_q.push_back({32'h2104, word_of(32'h2104)});
        chk("unhold_re", {31'b0, icache_re}, 32'd0);
        drive(0, 32'hBAD2_BAD2, 0, 0, 2'd0, 0);
        chk("reissue_state", {30'b0, fsm_state}, 32'd0);
        chk("reissue_addr", icache_addr, 32'h2108);
        chk("reissue_re", {31'b0, icache_re}, 32'd1);

        // redirect while waiting: late response squashed
        drive(0, 0, 0, 0, 2'd0, 0);
        drive(0, 0, 0, 0, 2'd1, 32'h3000);
        chk("wredir_re", {31'b0, icache_re}, 32'd0);
        drive(1, word_of(32'h2108), 0, 0, 2'd0, 0);
        chk("wredir_valid", {31'b0, inst_valid}, 32'd0);
        chk("wredir_addr", icache_addr, 32'h3000);
        chk("wredir_re1", {31'b0, icache_re}, 32'd1);

        // wrap at the top of the address space
        drive(1, word_of(32'h3000), 0, 1, 2'd1, 32'hFFFF_FFFC);
        chk("wrap_redir_addr", icache_addr, 32'hFFFF_FFFC);
        drive(1, word_of(32'hFFFF_FFFC), 0, 0, 2'd0, 0);
        exp_q.push_back({32'hFFFF_FFFC, word_of(32'hFFFF_FFFC)});
        chk("wrap_addr", icache_addr, 32'h0000_0000);

        // random miss latency and stall length, sequential stream
        pc = 32'h0;
        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 3);
            s = $urandom_range(0, 2);
            for (int i = 0; i < k; i++) drive(0, 32'hFFFF_0000, $urandom_range(0, 1), 0, 2'd0, 0);
            if (s == 0) begin
                drive(1, word_of(pc), 0, 0, 2'd0, 0);
                exp_q.push_back({pc, word_of(pc)});
                chk("rnd_pc_I", pc_I, pc);
                chk("rnd_addr", icache_addr, pc + 32'd4);
            end else begin
                drive(1, word_of(pc), 1, 0, 2'd0, 0);
                for (int i = 1; i < s; i++) drive(0, 32'hFFFF_0001, 1, 0, 2'd0, 0);
                drive(0, 32'hFFFF_0002, 0, 0, 2'd0, 0);
                exp_q.push_back({pc, word_of(pc)});
                chk("rnd_hold_pc_I", pc_I, pc);
                drive(0, 32'hFFFF_0003, 0, 0, 2'd0, 0);
                chk("rnd_issue_addr", icache_addr, pc + 32'd4);
            end
            pc = pc + 32'd4;
        end

        // asynchronous reset in the middle of HOLD
        drive(1, word_of(pc), 1, 0, 2'd0, 0);
        drive(0, 0, 1, 0, 2'd0, 0);
        #1 reset = 1'b1;
        #1;
        chk("arst_inst", inst, NOP);
        chk("arst_valid", {31'b0, inst_valid}, 32'd0);
        chk("arst_re", {31'b0, icache_re}, 32'd1);
        chk("arst_addr", icache_addr, 32'h2000);
        chk("arst_state", {30'b0, fsm_state}, 32'd0);
        @(posedge clk); #1 reset = 1'b0; stall = 1'b0;
        drive(1, word_of(32'h2000), 0, 0, 2'd0, 0);
        exp_q.push_back({32'h2000, word_of(32'h2000)});
        chk("reboot_addr", icache_addr, 32'h2004);
        drive(0, 0, 0, 0, 2'd0, 0);
        drive(0, 0, 0, 0, 2'd0, 0);
        chk("drain", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
